opcode_tag_decoder: RTL and testbench

- Decodes a 9-bit opcodeTagT stream (base + offset encoding: READ 0, WRITE 64, WAIT 128, EVICT 192, TRIM 256) into an opcodeEnumT type, a 6-bit index and an error flag.
- Sits at the consumer end of the opcode-tag link; it is the counterpart of the tag encoder.
- Input and output both use valid/ready handshakes, with a 2-entry output buffer and an illegal-tag statistics counter.

---
 rtl/opcode_tag_decoder_pkg.sv | 31 +++
 rtl/opcode_dec_fifo.sv | 62 ++++++
 rtl/opcode_tag_decoder.sv | 87 ++++++++
 tb/tb_opcode_tag_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/opcode_tag_decoder_pkg.sv
// Shared opcode-tag types: base+offset tag encoding and the decoded entry format.
package opcode_tag_decoder_pkg;

  localparam int OPCODEA_TAG_W     = 9;
  localparam int OPCODEA_IDX_W     = 6;
  localparam int OPCODEA_NUM_TYPES = 5;

  typedef logic [OPCODEA_TAG_W-1:0] opcodeTagT;
  typedef logic [OPCODEA_IDX_W-1:0] opcodeIdxT;

  typedef enum logic [2:0] {
    OPCODEATYPE_READ  = 3'd0,
    OPCODEATYPE_WRITE = 3'd1,
    OPCODEATYPE_WAIT  = 3'd2,
    OPCODEATYPE_EVICT = 3'd3,
    OPCODEATYPE_TRIM  = 3'd4
  } opcodeEnumT;

  localparam opcodeTagT OPCODEABASE_READ  = 9'd0;
  localparam opcodeTagT OPCODEABASE_WRITE = 9'd64;
  localparam opcodeTagT OPCODEABASE_WAIT  = 9'd128;
  localparam opcodeTagT OPCODEABASE_EVICT = 9'd192;
  localparam opcodeTagT OPCODEABASE_TRIM  = 9'd256;

  typedef struct packed {
    opcodeEnumT opcode;
    opcodeIdxT  index;
    logic       err;
  } opcodeDecSt;

endpackage

// File: rtl/opcode_dec_fifo.sv
// Two-entry valid/ready FIFO of decoded opcode entries.
// Push ready is registered from the next count, so it never depends on i_pop_ready.
module opcode_dec_fifo
  import opcode_tag_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push_valid,
  output logic       o_push_ready,
  input  opcodeDecSt i_push_data,
  output logic       o_pop_valid,
  input  logic       i_pop_ready,
  output opcodeDecSt o_pop_data
);

  opcodeDecSt r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_ready;
  logic [1:0] w_count_nxt;
  logic       w_push;
  logic       w_pop;

  assign w_push = i_push_valid & r_ready;
  assign w_pop  = (r_count != 2'd0) & i_pop_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign o_push_ready = r_ready;
  assign o_pop_valid  = (r_count != 2'd0);
  assign o_pop_data   = r_mem[r_rd_ptr];

endmodule

// File: rtl/opcode_tag_decoder.sv
// Consumer end of the opcode-tag link: decodes base+offset tags into type/index/err,
// buffers them in a 2-entry FIFO and keeps saturating illegal-tag statistics.
module opcode_tag_decoder
  import opcode_tag_decoder_pkg::*;
#(
  parameter int TAG_W        = 9,
  parameter int IDX_W        = 6,
  parameter int CNT_W        = 16,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output opcodeEnumT       out_opcode,
  output logic [IDX_W-1:0] out_index,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam logic [TAG_W-IDX_W-1:0] MAX_TYPE = (TAG_W-IDX_W)'(OPCODEA_NUM_TYPES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};

  logic [TAG_W-IDX_W-1:0] w_type;
  logic                   w_illegal;
  logic                   w_accept;
  logic                   w_acc_ill;
  logic                   w_push_valid;
  opcodeDecSt             w_dec;
  opcodeDecSt             w_head;
  logic [CNT_W-1:0]       r_err_cnt;
  logic                   r_err_sticky;

  assign w_type    = in_tag[TAG_W-1:IDX_W];
  assign w_illegal = (w_type > MAX_TYPE);

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = w_illegal ? OPCODEATYPE_READ : opcodeEnumT'(w_type);
    w_dec.index  = in_tag[IDX_W-1:0];
    w_dec.err    = w_illegal;
  end

  assign w_accept     = in_valid & in_ready;
  assign w_acc_ill    = w_accept & w_illegal;
  // Dropped illegal tags still complete the handshake; they just never reach the buffer.
  assign w_push_valid = in_valid & ~(DROP_ILLEGAL & w_illegal);

  opcode_dec_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (w_push_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_dec),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_head)
  );

  assign out_opcode = w_head.opcode;
  assign out_index  = w_head.index;
  assign out_err    = w_head.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (err_clr) begin
      r_err_cnt    <= w_acc_ill ? CNT_W'(1) : '0;
      r_err_sticky <= w_acc_ill;
    end else if (w_acc_ill) begin
      if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      r_err_sticky <= 1'b1;
    end
  end

  assign err_cnt    = r_err_cnt;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_opcode_tag_decoder.sv
// Directed bench for opcode_tag_decoder: forwarding and dropping variants side by side.
module tb_opcode_tag_decoder;
  import opcode_tag_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_err, err_sticky, err_clr;
  logic [8:0] in_tag;
  opcodeEnumT out_opcode;
  logic [5:0] out_index;
  logic [15:0] err_cnt;

  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_err, d_err_sticky, d_err_clr;
  logic [8:0] d_in_tag;
  opcodeEnumT d_out_opcode;
  logic [5:0] d_out_index;
  logic [15:0] d_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  opcode_tag_decoder #(.DROP_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_index(out_index), .out_err(out_err), .err_cnt(err_cnt),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  opcode_tag_decoder #(.DROP_ILLEGAL(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_opcode(d_out_opcode),
    .out_index(d_out_index), .out_err(d_out_err), .err_cnt(d_err_cnt),
    .err_sticky(d_err_sticky), .err_clr(d_err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Packs {opcode,index,err} so one comparison covers the whole head entry.
  function automatic logic [31:0] ent(input logic [2:0] op, input logic [5:0] idx, input logic e);
    return {22'd0, op, idx, e};
  endfunction

  logic [8:0]  tags1 [5];
  logic [31:0] exp1  [5];
  logic [31:0] q [$];
  logic [31:0] front;
  logic [8:0]  next_tag;
  int sent, recv, cyc;

  initial begin
    tags1 = '{9'h000, 9'h045, 9'h0BF, 9'h0C1, 9'h13F};
    exp1  = '{ent(3'd0, 6'd0, 1'b0), ent(3'd1, 6'd5, 1'b0), ent(3'd2, 6'd63, 1'b0),
              ent(3'd3, 6'd1, 1'b0), ent(3'd4, 6'd63, 1'b0)};

    rst = 1'b1; in_valid = 1'b0; in_tag = '0; out_ready = 1'b1; err_clr = 1'b0;
    d_in_valid = 1'b0; d_in_tag = '0; d_out_ready = 1'b1; d_err_clr = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_head", ent(out_opcode, out_index, out_err), ent(3'd0, 6'd0, 1'b0));
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sticky", err_sticky, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1);

    // Legal tags, one per cycle, each presented the cycle after acceptance
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_tag = tags1[i];
      tick();
      chk("legal_valid", out_valid, 1);
      chk("legal_head", ent(out_opcode, out_index, out_err), exp1[i]);
    end

    in_tag = 9'h140;
    tick();
    chk("ill_head", ent(out_opcode, out_index, out_err), ent(3'd0, 6'd0, 1'b1));
    chk("ill_cnt", err_cnt, 1);
    chk("ill_sticky", err_sticky, 1);
    in_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_alone_cnt", err_cnt, 0);
    chk("clr_alone_sticky", err_sticky, 0);
    chk("drain_valid", out_valid, 0);

    // Dropping variant: illegal tag consumed silently
    d_in_valid = 1'b1; d_in_tag = 9'h1FF;
    tick();
    chk("drop_no_out", d_out_valid, 0);
    chk("drop_cnt", d_err_cnt, 1);
    d_in_tag = 9'h040;
    tick();
    chk("drop_fwd_valid", d_out_valid, 1);
    chk("drop_fwd_head", ent(d_out_opcode, d_out_index, d_out_err), ent(3'd1, 6'd0, 1'b0));
    d_in_valid = 1'b0;
    tick();
    chk("drop_empty", d_out_valid, 0);
    chk("drop_cnt_hold", d_err_cnt, 1);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 9'h001;
    tick();
    chk("bp_ready1", in_ready, 1);
    in_tag = 9'h041;
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head1", ent(out_opcode, out_index, out_err), ent(3'd0, 6'd1, 1'b0));
    in_tag = 9'h081;
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_stable", ent(out_opcode, out_index, out_err), ent(3'd0, 6'd1, 1'b0));
    out_ready = 1'b1;
    tick();
    chk("bp_head2", ent(out_opcode, out_index, out_err), ent(3'd1, 6'd1, 1'b0));
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_head3", ent(out_opcode, out_index, out_err), ent(3'd2, 6'd1, 1'b0));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 0);

    // Saturation on the dropping instance (illegal tags never fill its buffer)
    d_err_clr = 1'b1;
    tick();
    d_err_clr = 1'b0;
    chk("sat_cleared", d_err_cnt, 0);
    d_in_valid = 1'b1; d_in_tag = 9'h1FF;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_full", d_err_cnt, 16'hFFFF);
    tick();
    chk("sat_hold", d_err_cnt, 16'hFFFF);
    chk("sat_sticky", d_err_sticky, 1);
    d_err_clr = 1'b1;
    tick();
    d_err_clr = 1'b0; d_in_valid = 1'b0;
    chk("clr_with_ill_cnt", d_err_cnt, 1);
    chk("clr_with_ill_sticky", d_err_sticky, 1);

    // Reset with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 9'h145;
    tick();
    in_tag = 9'h002;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", err_cnt, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("after_rst_ready", in_ready, 1);
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 9'h100;
    tick();
    in_valid = 1'b0;
    chk("after_rst_head", ent(out_opcode, out_index, out_err), ent(3'd4, 6'd0, 1'b0));
    tick();

    // Random valid/ready over legal tags with an order-checking scoreboard
    sent = 0; recv = 0; cyc = 0;
    next_tag = 9'($urandom_range(0, 319));
    while (recv < 1000 && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_tag    = next_tag;
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        front = q.pop_front();
        chk("rand_entry", ent(out_opcode, out_index, out_err), front);
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ent(3'(next_tag / 64), 6'(next_tag % 64), 1'b0));
        sent++;
        next_tag = 9'($urandom_range(0, 319));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_recv", recv, 1000);
    chk("rand_sent", sent, 1000);
    chk("rand_q_empty", q.size(), 0);
    chk("rand_err_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
